// File: rtl/br_resolve.sv
// br_resolve: branch resolution and architectural PC for the RV32I core.
// Decides taken/not-taken from the ALU branch flags, computes the target,
// redirects fetch, kills FLUSH_CYCLES wrong-path slots after each redirect
// and traps (sticky) on a misaligned taken target.
// Optional feature: define BR_STATS_EN to add taken_cnt / ntaken_cnt.
module br_resolve #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  localparam int         WORDSIZE     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_valid,
  input  logic                jal,
  input  logic                jalr,
  input  logic [2:0]          funct3,
  input  logic [1:0]          alu_br_ops,
  input  logic [WORDSIZE-1:0] alu_out,
  input  logic [WORDSIZE-1:0] imm,
  output logic [WORDSIZE-1:0] pc,
  output logic [WORDSIZE-1:0] link,
  output logic                redirect,
  output logic                inst_kill,
`ifdef BR_STATS_EN
  output logic [31:0]         taken_cnt,
  output logic [31:0]         ntaken_cnt,
`endif
  output logic                trap
);

  // Branch condition codes (RV32I funct3)
  localparam logic [2:0] FUNCT_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT_BNE  = 3'b001;
  localparam logic [2:0] FUNCT_BLT  = 3'b100;
  localparam logic [2:0] FUNCT_BGE  = 3'b101;
  localparam logic [2:0] FUNCT_BLTU = 3'b110;
  localparam logic [2:0] FUNCT_BGEU = 3'b111;

  // ALU comparison flag encoding
  localparam logic [1:0] ALU_BR_EQ = 2'd0;
  localparam logic [1:0] ALU_BR_LT = 2'd1;
  localparam logic [1:0] ALU_BR_GT = 2'd2;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_e;

  state_e              state_q, state_d;
  logic [WORDSIZE-1:0] pc_q, pc_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                redirect_q, redirect_d;
  logic                trap_q, trap_d;

  logic                br_cond;
  logic                xfer_taken;
  logic                br_resolved;
  logic [WORDSIZE-1:0] target;
  logic                misaligned;

  // Condition evaluation from the ALU flags; unknown funct3 never takes
  always_comb begin
    br_cond = 1'b0;
    unique case (funct3)
      FUNCT_BEQ:              br_cond = (alu_br_ops == ALU_BR_EQ);
      FUNCT_BNE:              br_cond = (alu_br_ops == ALU_BR_LT) || (alu_br_ops == ALU_BR_GT);
      FUNCT_BLT, FUNCT_BLTU:  br_cond = (alu_br_ops == ALU_BR_LT);
      FUNCT_BGE, FUNCT_BGEU:  br_cond = (alu_br_ops == ALU_BR_EQ) || (alu_br_ops == ALU_BR_GT);
      default:                br_cond = 1'b0;
    endcase
  end

  // Target select and taken decision; jalr beats jal beats br_valid
  always_comb begin
    target      = pc_q + imm;
    xfer_taken  = 1'b0;
    br_resolved = 1'b0;
    if (jalr) begin
      target     = alu_out & ~32'd1;
      xfer_taken = 1'b1;
    end else if (jal) begin
      xfer_taken = 1'b1;
    end else if (br_valid) begin
      xfer_taken  = br_cond;
      br_resolved = 1'b1;
    end
    misaligned = (target[1:0] != 2'b00);
  end

  // FSM next-state, PC, flush counter, redirect pulse and sticky trap
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    redirect_d = redirect_q;
    trap_d     = trap_q;
    if (!stall) begin
      redirect_d = 1'b0;
      unique case (state_q)
        RUN: begin
          if (xfer_taken && misaligned) begin
            // PC stays on the offending instruction for the trap handler
            trap_d  = 1'b1;
            state_d = TRAP;
          end else if (xfer_taken) begin
            pc_d       = target;
            redirect_d = 1'b1;
            cnt_d      = FLUSH_INIT;
            state_d    = FLUSH;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        FLUSH: begin
          // Transfers seen here are wrong-path and deliberately ignored
          pc_d  = pc_q + 32'd4;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        TRAP: ;
        default: state_d = RUN;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      redirect_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      trap_q     <= trap_d;
    end
  end

  assign pc        = pc_q;
  assign link      = pc_q + 32'd4;
  assign redirect  = redirect_q;
  assign trap      = trap_q;
  assign inst_kill = (state_q != RUN);

`ifdef BR_STATS_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] ntaken_cnt_q, ntaken_cnt_d;

  // Saturating counters of conditional branches resolved in RUN; traps excluded
  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (!stall && state_q == RUN && br_resolved) begin
      if (xfer_taken && !misaligned) begin
        if (taken_cnt_q != 32'hFFFF_FFFF) taken_cnt_d = taken_cnt_q + 32'd1;
      end else if (!xfer_taken) begin
        if (ntaken_cnt_q != 32'hFFFF_FFFF) ntaken_cnt_d = ntaken_cnt_q + 32'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt_q  <= 32'd0;
      ntaken_cnt_q <= 32'd0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// tb_br_resolve: directed steps plus randomized traffic against a
// cycle-level behavioural model of the branch/PC unit.
module tb_br_resolve;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          FC  = 2;
  localparam logic [1:0]  EQ  = 2'd0;
  localparam logic [1:0]  LT  = 2'd1;
  localparam logic [1:0]  GT  = 2'd2;

  logic        clk = 1'b0;
  logic        rst, stall, br_valid, jal, jalr;
  logic [2:0]  funct3;
  logic [1:0]  alu_br_ops;
  logic [31:0] alu_out, imm;
  logic [31:0] pc, link;
  logic        redirect, inst_kill, trap;
`ifdef BR_STATS_EN
  logic [31:0] taken_cnt, ntaken_cnt;
`endif

  br_resolve #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .jal(jal),
    .jalr(jalr), .funct3(funct3), .alu_br_ops(alu_br_ops), .alu_out(alu_out),
    .imm(imm), .pc(pc), .link(link), .redirect(redirect), .inst_kill(inst_kill),
`ifdef BR_STATS_EN
    .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt),
`endif
    .trap(trap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  int          m_kill_left;
  bit          m_trap, m_redir;
  logic [31:0] m_tc, m_nc;

  function automatic bit cond_taken(input logic [2:0] f3, input logic [1:0] fl);
    bit eq, lt, gt;
    eq = (fl == EQ); lt = (fl == LT); gt = (fl == GT);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] tgt;
    bit          tk;
    if (rst) begin
      m_pc = RPC; m_kill_left = 0; m_trap = 0; m_redir = 0; m_tc = 0; m_nc = 0;
    end else if (stall || m_trap) begin
      if (!stall) m_redir = 0;
    end else if (m_kill_left > 0) begin
      m_pc = m_pc + 32'd4; m_kill_left--; m_redir = 0;
    end else begin
      tk  = 0;
      tgt = m_pc + imm;
      if (jalr)          begin tk = 1; tgt = {alu_out[31:1], 1'b0}; end
      else if (jal)      tk = 1;
      else if (br_valid) tk = cond_taken(funct3, alu_br_ops);
      if (br_valid && !jal && !jalr) begin
        if (tk && tgt[1:0] == 2'b00) begin if (m_tc != '1) m_tc++; end
        else if (!tk)                begin if (m_nc != '1) m_nc++; end
      end
      m_redir = 0;
      if (tk && tgt[1:0] != 2'b00) m_trap = 1;
      else if (tk) begin m_pc = tgt; m_redir = 1; m_kill_left = FC; end
      else m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("link", link, m_pc + 32'd4);
    chk("redirect", {31'd0, redirect}, {31'd0, m_redir});
    chk("inst_kill", {31'd0, inst_kill}, {31'd0, (m_kill_left > 0) || m_trap});
    chk("trap", {31'd0, trap}, {31'd0, m_trap});
`ifdef BR_STATS_EN
    chk("taken_cnt", taken_cnt, m_tc);
    chk("ntaken_cnt", ntaken_cnt, m_nc);
`endif
  endtask

  task automatic step(input logic r, input logic s, input logic bv, input logic j,
                      input logic jr, input logic [2:0] f3, input logic [1:0] fl,
                      input logic [31:0] ao, input logic [31:0] im);
    rst = r; stall = s; br_valid = bv; jal = j; jalr = jr;
    funct3 = f3; alu_br_ops = fl; alu_out = ao; imm = im;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 3'd0, EQ, 32'd0, 32'd0);
  endtask

  task automatic go_jalr(input logic [31:0] t);
    step(0, 0, 0, 0, 1, 3'd0, EQ, t, 32'd0);
  endtask

  initial begin
    rst = 1; stall = 0; br_valid = 0; jal = 0; jalr = 0;
    funct3 = 0; alu_br_ops = 0; alu_out = 0; imm = 0;
    m_pc = 0; m_kill_left = 0; m_trap = 0; m_redir = 0; m_tc = 0; m_nc = 0;

    // Reset and sequential fetch
    step(1, 0, 0, 0, 0, 3'd0, EQ, 32'd0, 32'd0);
    chk("rst_pc", pc, 32'h100);
    idle(1); chk("seq_pc1", pc, 32'h104);
    idle(1); chk("seq_pc2", pc, 32'h108);
    idle(1); chk("seq_pc3", pc, 32'h10C);

    // Taken BEQ from 0x200 and its two-slot flush
    go_jalr(32'h1F8); idle(2); chk("at_200", pc, 32'h200);
    step(0, 0, 1, 0, 0, 3'd0, EQ, 32'd0, 32'h40);
    chk("beq_pc", pc, 32'h240); chk("beq_redir", {31'd0, redirect}, 32'd1);
    chk("beq_kill1", {31'd0, inst_kill}, 32'd1);
    idle(1); chk("beq_kill2", {31'd0, inst_kill}, 32'd1);
    chk("beq_redir_off", {31'd0, redirect}, 32'd0);
    idle(1); chk("beq_after", pc, 32'h248); chk("beq_nokill", {31'd0, inst_kill}, 32'd0);

    // Not-taken BGE, then taken BNE with negative offset
    go_jalr(32'h2F8); idle(2);
    step(0, 0, 1, 0, 0, 3'd5, LT, 32'd0, 32'h40);
    chk("bge_nt_pc", pc, 32'h304); chk("bge_nt_kill", {31'd0, inst_kill}, 32'd0);
    step(0, 0, 1, 0, 0, 3'd1, GT, 32'd0, 32'hFFFF_FFF8);
    chk("bne_pc", pc, 32'h2FC);
    idle(2);

    // Misaligned JALR traps; pc holds, JAL ignored; reset releases
    go_jalr(32'h1003);
    chk("trap_pc", pc, 32'h304); chk("trap_set", {31'd0, trap}, 32'd1);
    idle(5);
    step(0, 0, 0, 1, 0, 3'd0, EQ, 32'd0, 32'h40);
    idle(4);
    chk("trap_hold_pc", pc, 32'h304); chk("trap_kill", {31'd0, inst_kill}, 32'd1);
    step(1, 0, 0, 0, 0, 3'd0, EQ, 32'd0, 32'd0);
    chk("trap_rst_pc", pc, RPC); chk("trap_rst", {31'd0, trap}, 32'd0);
    chk("trap_rst_kill", {31'd0, inst_kill}, 32'd0);

    // JAL held off by stall, then a JAL during FLUSH is discarded
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0, 3'd0, EQ, 32'd0, 32'h80);
    chk("stall_pc", pc, 32'h100); chk("stall_redir", {31'd0, redirect}, 32'd0);
    step(0, 0, 0, 1, 0, 3'd0, EQ, 32'd0, 32'h80);
    chk("jal_pc", pc, 32'h180);
    step(0, 0, 0, 1, 0, 3'd0, EQ, 32'd0, 32'h80);
    chk("flush_jal_ign", pc, 32'h184);
    idle(1);

    // Target and link wrap-around
    go_jalr(32'hFFFF_FFE8); idle(2); chk("at_fff0", pc, 32'hFFFF_FFF0);
    step(0, 0, 0, 1, 0, 3'd0, EQ, 32'd0, 32'h20);
    chk("wrap_pc", pc, 32'h10);
    idle(2);
    go_jalr(32'hFFFF_FFFC); chk("link_wrap", link, 32'h0);
    idle(2); chk("pc_wrap", pc, 32'h4);

    // Statistics: 5 taken, 3 not-taken branches and 2 JALs
    step(1, 0, 0, 0, 0, 3'd0, EQ, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, 3'd0, EQ, 32'd0, 32'h8); idle(2);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 3'd4, GT, 32'd0, 32'h8);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 1, 0, 3'd0, EQ, 32'd0, 32'h8); idle(2);
    end
`ifdef BR_STATS_EN
    chk("stats_taken", taken_cnt, 32'd5);
    chk("stats_ntaken", ntaken_cnt, 32'd3);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic r, s, bv, j, jr;
      logic [1:0]  fl;
      logic [31:0] ao, im;
      int kind;
      r  = m_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 4) == 0);
      kind = $urandom_range(0, 7);
      bv = (kind == 4) || (kind == 7);
      j  = (kind == 5) || ((kind == 7) && $urandom_range(0, 1) == 1);
      jr = (kind == 6) || ((kind == 7) && $urandom_range(0, 1) == 1);
      fl = 2'($urandom_range(0, 2));
      im = 32'($urandom_range(0, 63) * 4) - 32'd128;
      if ($urandom_range(0, 7) == 0) im = im + 32'd2;
      ao = $urandom;
      if ($urandom_range(0, 4) != 0) ao[1] = 1'b0;
      step(r, s, bv, j, jr, 3'($urandom_range(0, 7)), fl, ao, im);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
